cache_word_select: RTL and testbench

CACHE_WORD_SELECT -- requirements
Module: cache_word_select

---
 rtl/lc3b_types.sv | 21 ++
 rtl/onehot_prio_enc.sv | 35 +++
 rtl/cache_word_select.sv | 137 +++++++++++++
 tb/tb_cache_word_select.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus defaults and helpers for the cache word selector.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [3:0]   lc3b_offset;

  localparam int DEF_WAYS       = 2;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_WORD_BYTES = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index priority encoder: one-hot result, binary index, and a flag when
// the input vector is not exactly one-hot (zero or multiple bits set).
module onehot_prio_enc #(
  parameter int WAYS = 2,
  localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  vec,
  output logic [WAYS-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             not_onehot
);

  logic [WAYS-1:0] vec_m1_s;

  // Scan upward so the first set bit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (vec[i] && !any) begin
        onehot[i] = 1'b1;
        idx       = i[IDX_W-1:0];
        any       = 1'b1;
      end else begin
        onehot[i] = onehot[i];
      end
    end
  end

  assign vec_m1_s   = vec - WAYS'(1);
  assign not_onehot = (vec == '0) || ((vec & vec_m1_s) != '0);

endmodule

// File: rtl/cache_word_select.sv
// Selects the hitting way's line and addressed word, optionally merges a masked
// write word into the line, and presents the result through a one-entry response register.
module cache_word_select
  import lc3b_types::*;
#(
  parameter int WAYS       = DEF_WAYS,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  localparam int LINE_BITS = 8 * LINE_BYTES,
  localparam int WORD_BITS = 8 * WORD_BYTES,
  localparam int OFF_W     = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WAYS*LINE_BITS-1:0] lines,
  input  logic [WAYS-1:0]           hit,
  input  logic [OFF_W-1:0]          offset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      wr,
  input  logic [WORD_BITS-1:0]      wdata,
  input  logic [WORD_BYTES-1:0]     wmask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_BITS-1:0]      rsp_word,
  output logic [LINE_BITS-1:0]      rsp_line,
  output logic [WAYS-1:0]           rsp_way,
  output logic                      rsp_err,
  output logic [7:0]                err_count
);

  localparam int WOFF_W    = $clog2(WORD_BYTES);
  localparam int WORDS     = LINE_BYTES / WORD_BYTES;
  localparam int WIDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAY_IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]      way_oh_s;
  logic [WAY_IDX_W-1:0] way_idx_s;
  logic                 way_any_s;
  logic                 way_err_s;
  logic [WIDX_W-1:0]    word_idx_s;
  logic [LINE_BITS-1:0] sel_line_s;
  logic [LINE_BITS-1:0] merged_line_s;
  logic [WORD_BITS-1:0] sel_word_s;
  logic                 accept_s;
  logic                 unused_off_s;

  rsp_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] rsp_word_q;
  logic [LINE_BITS-1:0] rsp_line_q;
  logic [WAYS-1:0]      rsp_way_q;
  logic                 rsp_err_q;
  logic [7:0]           err_count_q, err_count_d;

  onehot_prio_enc #(.WAYS(WAYS)) u_enc (
    .vec        (hit),
    .onehot     (way_oh_s),
    .idx        (way_idx_s),
    .any        (way_any_s),
    .not_onehot (way_err_s)
  );

  // Byte-within-word offset bits do not address anything.
  generate
    if (WORDS > 1) begin : g_widx
      assign word_idx_s = offset[OFF_W-1:WOFF_W];
    end else begin : g_widx_one
      assign word_idx_s = '0;
    end
  endgenerate
  assign unused_off_s = ^offset;

  // Line and word selection with masked write-merge; no hit yields all zeros.
  always_comb begin
    int wbase;
    wbase         = int'(word_idx_s) * WORD_BITS;
    sel_line_s    = '0;
    if (way_any_s) begin
      sel_line_s = lines[int'(way_idx_s) * LINE_BITS +: LINE_BITS];
    end else begin
      sel_line_s = '0;
    end
    sel_word_s    = sel_line_s[wbase +: WORD_BITS];
    merged_line_s = sel_line_s;
    for (int b = 0; b < WORD_BYTES; b++) begin
      merged_line_s[wbase + 8*b +: 8] = (wr && way_any_s && wmask[b]) ?
                                        wdata[8*b +: 8] : sel_line_s[wbase + 8*b +: 8];
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept_s  = req_valid && req_ready;

  // Next-state for the response register occupancy and the error counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = accept_s ? ST_FULL : ST_EMPTY;
      ST_FULL:  state_d = (rsp_ready && !accept_s) ? ST_EMPTY : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept_s && way_err_s) begin
      err_count_d = sat_inc8(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Response register: loads only on accept, so a stalled response stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rsp_word_q  <= '0;
      rsp_line_q  <= '0;
      rsp_way_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      if (accept_s) begin
        rsp_word_q <= sel_word_s;
        rsp_line_q <= merged_line_s;
        rsp_way_q  <= way_oh_s;
        rsp_err_q  <= way_err_s;
      end
    end
  end

  assign rsp_word  = rsp_word_q;
  assign rsp_line  = rsp_line_q;
  assign rsp_way   = rsp_way_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_cache_word_select.sv
// Directed bench for cache_word_select at default parameters.
module tb_cache_word_select;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] lines;
  logic [1:0]   hit;
  logic [3:0]   offset;
  logic         req_valid;
  logic         req_ready;
  logic         wr;
  logic [15:0]  wdata;
  logic [1:0]   wmask;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [15:0]  rsp_word;
  logic [127:0] rsp_line;
  logic [1:0]   rsp_way;
  logic         rsp_err;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] LINE0 = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [127:0] LINE1 = 128'h0F0E0D0C0B0A09080706050403020100;

  cache_word_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lines     (lines),
    .hit       (hit),
    .offset    (offset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .wr        (wr),
    .wdata     (wdata),
    .wmask     (wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_word  (rsp_word),
    .rsp_line  (rsp_line),
    .rsp_way   (rsp_way),
    .rsp_err   (rsp_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    lines     = {LINE1, LINE0};
    hit       = 2'b00;
    offset    = 4'h0;
    req_valid = 1'b0;
    wr        = 1'b0;
    wdata     = 16'h0000;
    wmask     = 2'b00;
    rsp_ready = 1'b1;
    #2;
    check("rst_valid", {127'b0, rsp_valid}, 128'h0);
    check("rst_line", rsp_line, 128'h0);
    check("rst_errcnt", {120'b0, err_count}, 128'h0);
    check("rst_req_ready", {127'b0, req_ready}, 128'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Read from way1, word 2
    hit = 2'b10; offset = 4'h5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rd_valid", {127'b0, rsp_valid}, 128'h1);
    check("rd_word", {112'b0, rsp_word}, {112'b0, 16'h0504});
    check("rd_way", {126'b0, rsp_way}, {126'b0, 2'b10});
    check("rd_err", {127'b0, rsp_err}, 128'h0);
    check("rd_line", rsp_line, LINE1);

    // Write-merge high byte of word 7 in way0
    hit = 2'b01; offset = 4'hE; wr = 1'b1; wdata = 16'hBEEF; wmask = 2'b10; req_valid = 1'b1;
    tick();
    check("wr_line", rsp_line, 128'hBE2233445566778899AABBCCDDEEFF00);
    check("wr_word", {112'b0, rsp_word}, {112'b0, 16'h1122});
    check("wr_way", {126'b0, rsp_way}, {126'b0, 2'b01});

    // Full-mask write of word 0
    offset = 4'h1; wmask = 2'b11;
    tick();
    check("wr2_line", rsp_line, 128'h112233445566778899AABBCCDDEEBEEF);
    check("wr2_word", {112'b0, rsp_word}, {112'b0, 16'hFF00});

    // Backpressure: load way1 word0, then stall three cycles
    wr = 1'b0; wdata = 16'h0000; wmask = 2'b00; hit = 2'b10; offset = 4'h0;
    tick();
    rsp_ready = 1'b0; hit = 2'b01; offset = 4'h2;
    #1;
    check("bp_req_ready", {127'b0, req_ready}, 128'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_valid", {127'b0, rsp_valid}, 128'h1);
      check("bp_word", {112'b0, rsp_word}, {112'b0, 16'h0100});
      check("bp_way", {126'b0, rsp_way}, {126'b0, 2'b10});
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {127'b0, req_ready}, 128'h1);
    tick();
    req_valid = 1'b0;
    check("bp_next_valid", {127'b0, rsp_valid}, 128'h1);
    check("bp_next_word", {112'b0, rsp_word}, {112'b0, 16'hDDEE});
    check("bp_next_way", {126'b0, rsp_way}, {126'b0, 2'b01});
    tick();
    check("drain_empty", {127'b0, rsp_valid}, 128'h0);

    // No hit, then multi-hit
    hit = 2'b00; offset = 4'h5; req_valid = 1'b1;
    tick();
    check("nohit_word", {112'b0, rsp_word}, 128'h0);
    check("nohit_line", rsp_line, 128'h0);
    check("nohit_way", {126'b0, rsp_way}, 128'h0);
    check("nohit_err", {127'b0, rsp_err}, 128'h1);
    check("nohit_cnt", {120'b0, err_count}, 128'h1);
    hit = 2'b11;
    tick();
    check("multi_way", {126'b0, rsp_way}, {126'b0, 2'b01});
    check("multi_word", {112'b0, rsp_word}, {112'b0, 16'hBBCC});
    check("multi_err", {127'b0, rsp_err}, 128'h1);
    check("multi_cnt", {120'b0, err_count}, {120'b0, 8'd2});

    // Saturation: 258 more errored accepts (260 total)
    hit = 2'b00;
    for (int n = 0; n < 252; n++) tick();
    check("sat_254", {120'b0, err_count}, {120'b0, 8'd254});
    tick();
    check("sat_255", {120'b0, err_count}, {120'b0, 8'd255});
    for (int n = 0; n < 5; n++) tick();
    check("sat_hold", {120'b0, err_count}, {120'b0, 8'd255});

    // Asynchronous reset while FULL and stalled
    req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    check("pre_rst_valid", {127'b0, rsp_valid}, 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'b0, rsp_valid}, 128'h0);
    check("async_rst_cnt", {120'b0, err_count}, 128'h0);
    check("async_rst_err", {127'b0, rsp_err}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First accept after reset behaves as from EMPTY
    hit = 2'b10; offset = 4'h5; req_valid = 1'b1;
    #1;
    check("post_rst_ready", {127'b0, req_ready}, 128'h1);
    tick();
    req_valid = 1'b0;
    check("post_rst_valid", {127'b0, rsp_valid}, 128'h1);
    check("post_rst_word", {112'b0, rsp_word}, {112'b0, 16'h0504});
    check("post_rst_cnt", {120'b0, err_count}, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
